mem_port_arbiter: RTL and testbench

- Shares one single-port synchronous unified memory between the Cpu instruction-fetch port and its load/store data port.
- Each access runs as a 3-state sequence: the block arbitrates, issues one memory command, then returns the response with a one-cycle valid pulse.
- Handles byte/half/word lanes using the Cpu's MemSize (funct3) encoding. Flags misaligned data accesses without touching memory.
- Sits between Cpu and memory, replacing the separate InstructionMemory and data-memory hookup.

---
 rtl/mem_port_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between the instruction-fetch port
// and the load/store port; each access runs IDLE -> ISSUE -> RESP.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int MEM_AW   = 10,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_valid,
  output logic              d_err,
  output logic              mem_en,
  output logic [3:0]        mem_be,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  // state  | meaning
  // IDLE   | pick a winner and latch its command
  // ISSUE  | memory command on mem_*; mem_en low for a rejected data access
  // RESP   | one-cycle valid pulse, read data comes straight from mem_rdata
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

  logic [1:0]        r_state;
  logic [3:0]        r_wait_cnt;
  logic              r_is_fetch;
  logic              r_we;
  logic              r_bad;
  logic [2:0]        r_size;
  logic [1:0]        r_off;
  logic              r_mem_en;
  logic [3:0]        r_mem_be;
  logic [MEM_AW-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_if_valid;
  logic              r_d_valid;
  logic              r_d_err;
  logic [31:0]       r_if_hold;
  logic [31:0]       r_d_hold;

  logic        w_fetch_win;
  logic        w_d_bad;
  logic [3:0]  w_st_be;
  logic [31:0] w_st_wdata;
  logic [31:0] w_rsh;
  logic [31:0] w_load_data;
  logic        w_unused_bits;

  assign w_unused_bits = ^{if_addr[1:0], if_addr[ADDR_W-1:MEM_AW+2],
                           d_addr[ADDR_W-1:MEM_AW+2]};

  always_comb begin
    w_fetch_win = if_req && (!d_req || (r_wait_cnt >= LP_MAX_WAIT));
    w_d_bad     = 1'b1;
    w_st_be     = 4'b1111;
    w_st_wdata  = d_wdata;
    case (d_size)
      3'b000, 3'b100: begin
        w_d_bad    = 1'b0;
        w_st_be    = 4'b0001 << d_addr[1:0];
        w_st_wdata = {4{d_wdata[7:0]}};
      end
      3'b001, 3'b101: begin
        w_d_bad    = d_addr[0];
        w_st_be    = 4'b0011 << d_addr[1:0];
        w_st_wdata = {2{d_wdata[15:0]}};
      end
      3'b010:  w_d_bad = (d_addr[1:0] != 2'b00);
      default: w_d_bad = 1'b1;
    endcase
  end

  // Memory read data only exists during RESP, so the load result is formed
  // from mem_rdata in that cycle and captured into the hold register after.
  always_comb begin
    w_rsh = mem_rdata >> {r_off, 3'b000};
    case (r_size)
      3'b000:  w_load_data = {{24{w_rsh[7]}}, w_rsh[7:0]};
      3'b100:  w_load_data = {24'b0, w_rsh[7:0]};
      3'b001:  w_load_data = {{16{w_rsh[15]}}, w_rsh[15:0]};
      3'b101:  w_load_data = {16'b0, w_rsh[15:0]};
      default: w_load_data = mem_rdata;
    endcase
    if (r_we || r_d_err) w_load_data = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= '0;
      r_is_fetch  <= 1'b0;
      r_we        <= 1'b0;
      r_bad       <= 1'b0;
      r_size      <= '0;
      r_off       <= '0;
      r_mem_en    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_valid  <= 1'b0;
      r_d_valid   <= 1'b0;
      r_d_err     <= 1'b0;
      r_if_hold   <= '0;
      r_d_hold    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (if_req || d_req) begin
            r_state    <= S_ISSUE;
            r_is_fetch <= w_fetch_win;
            if (w_fetch_win) begin
              r_wait_cnt  <= '0;
              r_we        <= 1'b0;
              r_bad       <= 1'b0;
              r_size      <= 3'b010;
              r_off       <= 2'b00;
              r_mem_en    <= 1'b1;
              r_mem_be    <= 4'b0000;
              r_mem_addr  <= if_addr[MEM_AW+1:2];
              r_mem_wdata <= '0;
            end else begin
              if (if_req && r_wait_cnt != 4'hF) r_wait_cnt <= r_wait_cnt + 4'd1;
              r_we        <= d_we;
              r_bad       <= w_d_bad;
              r_size      <= d_size;
              r_off       <= d_addr[1:0];
              r_mem_en    <= !w_d_bad;
              r_mem_be    <= (d_we && !w_d_bad) ? w_st_be : 4'b0000;
              r_mem_addr  <= d_addr[MEM_AW+1:2];
              r_mem_wdata <= (d_we && !w_d_bad) ? w_st_wdata : '0;
            end
          end
        end
        S_ISSUE: begin
          r_mem_en    <= 1'b0;
          r_mem_be    <= '0;
          r_mem_addr  <= '0;
          r_mem_wdata <= '0;
          r_if_valid  <= r_is_fetch;
          r_d_valid   <= !r_is_fetch;
          r_d_err     <= !r_is_fetch && r_bad;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          r_if_valid <= 1'b0;
          r_d_valid  <= 1'b0;
          r_d_err    <= 1'b0;
          if (r_if_valid) r_if_hold <= mem_rdata;
          if (r_d_valid)  r_d_hold  <= w_load_data;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_en    = r_mem_en;
  assign mem_be    = r_mem_be;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_valid  = r_if_valid;
  assign d_valid   = r_d_valid;
  assign d_err     = r_d_err;
  assign if_rdata  = r_if_valid ? mem_rdata : r_if_hold;
  assign d_rdata   = r_d_valid ? w_load_data : r_d_hold;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level
// model that computes each grant's command and response from the access rules.
module tb_mem_port_arbiter;
  localparam int ADDR_W   = 32;
  localparam int MEM_AW   = 10;
  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_req;
  logic        d_we;
  logic [2:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        d_err;
  logic        mem_en;
  logic [3:0]  mem_be;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .MEM_AW(MEM_AW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_err(d_err),
    .mem_en(mem_en), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic cmp_en = 1'b0;
  logic log_en = 1'b0;
  byte  order[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory environment: synchronous single port, read data the cycle after mem_en.
  logic [31:0] env_mem [0:1023];
  always @(posedge clk) begin
    if (mem_en === 1'b1) begin
      if (mem_be == 4'b0000) mem_rdata <= env_mem[mem_addr];
      else
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) env_mem[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
    end
  end

  // Reference model: one entry per grant, timed by cycle arithmetic.
  logic [31:0] mdl_mem [0:1023];
  int          issue_cyc = -100;
  int          free_cyc = 0;
  int          wait_n = 0;
  logic        e_fetch, e_en, e_err;
  logic [3:0]  e_be;
  logic [9:0]  e_addr;
  logic [31:0] e_wdata, e_rdata;
  logic [31:0] last_if = '0;
  logic [31:0] last_d = '0;

  task automatic model_grant();
    logic        fw;
    int          o, nb;
    logic [31:0] w, mask;
    fw = if_req && (!d_req || wait_n >= MAX_WAIT);
    issue_cyc = cyc;
    free_cyc  = cyc + 3;
    e_fetch = fw; e_be = '0; e_wdata = '0; e_err = 1'b0; e_rdata = '0;
    if (fw) begin
      wait_n = 0;
      e_en   = 1'b1;
      e_addr = if_addr[11:2];
      e_rdata = mdl_mem[e_addr];
    end else begin
      if (if_req) wait_n = (wait_n < 15) ? wait_n + 1 : 15;
      o = int'(d_addr[1:0]);
      e_addr = d_addr[11:2];
      case (d_size)
        3'b000, 3'b100: nb = 1;
        3'b001, 3'b101: nb = 2;
        3'b010:         nb = 4;
        default:        nb = 0;
      endcase
      if (nb == 0 || (o % nb) != 0) begin
        e_en = 1'b0; e_err = 1'b1;
      end else if (d_we) begin
        e_en = 1'b1;
        for (int b = 0; b < 4; b++) begin
          e_wdata[8*b +: 8] = d_wdata[8*(b % nb) +: 8];
          if (b >= o && b < o + nb) begin
            e_be[b] = 1'b1;
            mdl_mem[e_addr][8*b +: 8] = d_wdata[8*(b-o) +: 8];
          end
        end
      end else begin
        e_en = 1'b1;
        w = mdl_mem[e_addr] >> (8*o);
        if (nb == 4) e_rdata = w;
        else begin
          mask = (32'h1 << (8*nb)) - 32'h1;
          e_rdata = w & mask;
          if (!d_size[2] && e_rdata[8*nb-1]) e_rdata = e_rdata | ~mask;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (cyc == issue_cyc + 2) begin
      if (e_fetch) last_if = e_rdata;
      else last_d = e_rdata;
    end
    if (reset) begin
      issue_cyc = -100; free_cyc = 0; wait_n = 0; last_if = '0; last_d = '0;
    end else if (cyc >= free_cyc && (if_req || d_req)) begin
      model_grant();
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      if (cyc == issue_cyc) begin
        chk("issue_mem_en", 32'(mem_en), 32'(e_en));
        if (e_en) begin
          chk("issue_mem_addr", 32'(mem_addr), 32'(e_addr));
          chk("issue_mem_be", 32'(mem_be), 32'(e_be));
          if (e_be != 4'b0000) chk("issue_mem_wdata", mem_wdata, e_wdata);
        end
        chk("issue_valids", 32'({if_valid, d_valid, d_err}), 32'd0);
      end else if (cyc == issue_cyc + 1) begin
        chk("resp_mem_en", 32'(mem_en), 32'd0);
        chk("resp_if_valid", 32'(if_valid), 32'(e_fetch));
        chk("resp_d_valid", 32'(d_valid), 32'(!e_fetch));
        chk("resp_d_err", 32'(d_err), 32'(e_err));
        chk("resp_if_rdata", if_rdata, e_fetch ? e_rdata : last_if);
        chk("resp_d_rdata", d_rdata, e_fetch ? last_d : e_rdata);
      end else begin
        chk("idle_mem_en", 32'(mem_en), 32'd0);
        chk("idle_valids", 32'({if_valid, d_valid, d_err}), 32'd0);
        chk("idle_if_rdata", if_rdata, last_if);
        chk("idle_d_rdata", d_rdata, last_d);
      end
    end
  end

  always @(negedge clk) begin
    if (log_en) begin
      if (if_valid) order.push_back(8'h46);
      if (d_valid)  order.push_back(8'h44);
    end
  end

  task automatic d_access(input logic we, input logic [2:0] sz, input logic [31:0] a,
                          input logic [31:0] wd_in, output logic [31:0] rd, output logic err,
                          output logic [3:0] be, output logic [31:0] wd, output logic [9:0] ad,
                          output int enl, output int vl);
    logic got;
    int   t0;
    rd = '0; err = 1'b0; be = '0; wd = '0; ad = '0; enl = -1; vl = -1; got = 1'b0;
    d_we = we; d_size = sz; d_addr = a; d_wdata = wd_in; d_req = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (mem_en && enl < 0) begin
        enl = cyc - t0; be = mem_be; wd = mem_wdata; ad = mem_addr;
      end
      if (d_valid) begin
        got = 1'b1; vl = cyc - t0; rd = d_rdata; err = d_err;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL d_access_timeout: no d_valid for addr %h, required within 40 cycles", a);
    end
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  task automatic f_access(input logic [31:0] a, output logic [31:0] rd, output int vl);
    logic got;
    int   t0;
    rd = '0; vl = -1; got = 1'b0;
    if_addr = a; if_req = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (if_valid) begin
        got = 1'b1; vl = cyc - t0; rd = if_rdata;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL f_access_timeout: no if_valid for addr %h, required within 40 cycles", a);
    end
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  logic [31:0] rd, wd, w0, frd;
  logic        err, seen;
  logic [3:0]  be;
  logic [9:0]  ad;
  int          enl, vl, nv;
  logic [31:0] instr [0:2];
  logic [31:0] arb_frd [0:1];
  logic [31:0] x_rd, x_wd;
  logic        x_err;
  logic [3:0]  x_be;
  logic [9:0]  x_ad;
  int          x_enl, x_vl, f_vl;
  string       ref_s, got_s;

  initial begin
    reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_size = 3'b010; d_addr = '0; d_wdata = '0;
    instr[0] = 32'h0000_0013; instr[1] = 32'h0010_0093; instr[2] = 32'h0020_0113;
    for (int i = 0; i < 1024; i++) begin
      w0 = $urandom;
      env_mem[i] = w0; mdl_mem[i] = w0;
    end
    for (int i = 0; i < 3; i++) begin env_mem[i] = instr[i]; mdl_mem[i] = instr[i]; end
    env_mem[4] = 32'hDEAD_BEEF; mdl_mem[4] = 32'hDEAD_BEEF;

    repeat (3) @(posedge clk);
    #1; reset = 1'b0; cmp_en = 1'b1;
    @(negedge clk);
    chk("reset_outputs", 32'({mem_en, mem_be, if_valid, d_valid, d_err}), 32'd0);
    chk("reset_mem_addr_wdata", mem_wdata | 32'(mem_addr), 32'd0);
    chk("reset_rdata", if_rdata | d_rdata, 32'd0);
    @(posedge clk); #1;

    d_access(1'b0, 3'b010, 32'h10, 32'h0, rd, err, be, wd, ad, enl, vl);
    chk("lw_rdata", rd, 32'hDEAD_BEEF);
    chk("lw_err", 32'(err), 32'd0);
    chk("lw_mem_en_latency", 32'(enl), 32'd1);
    chk("lw_mem_addr", 32'(ad), 32'd4);
    chk("lw_mem_be", 32'(be), 32'd0);
    chk("lw_valid_latency", 32'(vl), 32'd2);

    d_access(1'b1, 3'b000, 32'h13, 32'h0000_00A5, rd, err, be, wd, ad, enl, vl);
    chk("sb_mem_be", 32'(be), 32'h8);
    chk("sb_mem_wdata", wd, 32'hA5A5_A5A5);
    d_access(1'b0, 3'b000, 32'h13, 32'h0, rd, err, be, wd, ad, enl, vl);
    chk("lb_rdata", rd, 32'hFFFF_FFA5);
    d_access(1'b0, 3'b100, 32'h13, 32'h0, rd, err, be, wd, ad, enl, vl);
    chk("lbu_rdata", rd, 32'h0000_00A5);

    d_access(1'b1, 3'b001, 32'h12, 32'h0000_8001, rd, err, be, wd, ad, enl, vl);
    chk("sh_mem_be", 32'(be), 32'hC);
    chk("sh_mem_wdata", wd, 32'h8001_8001);
    d_access(1'b0, 3'b001, 32'h12, 32'h0, rd, err, be, wd, ad, enl, vl);
    chk("lh_rdata", rd, 32'hFFFF_8001);
    d_access(1'b0, 3'b001, 32'h11, 32'h0, rd, err, be, wd, ad, enl, vl);
    chk("lh_mis_err", 32'(err), 32'd1);
    chk("lh_mis_no_mem_en", 32'(enl), 32'hFFFF_FFFF);
    chk("lh_mis_rdata", rd, 32'd0);

    for (int k = 0; k < 3; k++) begin
      f_access(32'(k*4), frd, f_vl);
      chk("fetch_seq_word", frd, instr[k]);
      chk("fetch_seq_latency", 32'(f_vl), 32'd2);
    end

    // Reset while a store is in ISSUE.
    d_we = 1'b1; d_size = 3'b010; d_addr = 32'h20; d_wdata = 32'h55; d_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (mem_en) seen = 1'b1;
    end
    chk("rst_saw_issue", 32'(seen), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("rst_abort_outputs", 32'({mem_en, mem_be, if_valid, d_valid, d_err}), 32'd0);
    chk("rst_abort_addr_wdata", mem_wdata | 32'(mem_addr), 32'd0);
    chk("rst_abort_rdata", if_rdata | d_rdata, 32'd0);
    nv = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (d_valid) nv++;
    end
    chk("rst_no_valid", 32'(nv), 32'd0);
    @(posedge clk); #1;
    d_access(1'b0, 3'b010, 32'h20, 32'h0, rd, err, be, wd, ad, enl, vl);
    chk("after_rst_idle_latency", 32'(enl), 32'd1);

    // Both ports held: four data wins, then fetch.
    order.delete();
    log_en = 1'b1;
    fork
      begin
        for (int k = 0; k < 2; k++) begin
          f_access(32'(k*4), frd, f_vl);
          arb_frd[k] = frd;
        end
      end
      begin
        for (int k = 0; k < 8; k++)
          d_access(1'b0, 3'b010, 32'(32'h40 + k*4), 32'h0, x_rd, x_err, x_be, x_wd, x_ad, x_enl, x_vl);
      end
    join
    log_en = 1'b0;
    ref_s = "DDDDFDDDDF";
    got_s = "";
    foreach (order[i]) got_s = {got_s, (order[i] == 8'h46) ? "F" : "D"};
    checks++;
    if (got_s != ref_s) begin
      errors++;
      $display("FAIL arb_order: got %s expected %s", got_s, ref_s);
    end
    chk("arb_fetch0", arb_frd[0], instr[0]);
    chk("arb_fetch1", arb_frd[1], instr[1]);

    fork
      begin
        for (int k = 0; k < 100; k++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          f_access({$urandom_range(0, 1) ? 20'($urandom) : 20'h0, 12'($urandom_range(0, 4095))},
                   frd, f_vl);
        end
      end
      begin
        logic [2:0]  sz;
        logic [31:0] a;
        int          pick;
        for (int k = 0; k < 150; k++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          pick = $urandom_range(0, 9);
          case (pick)
            0: sz = 3'b000; 1: sz = 3'b001; 2: sz = 3'b100; 3: sz = 3'b101;
            4: sz = 3'b011; 5: sz = 3'b110; 6: sz = 3'b111; default: sz = 3'b010;
          endcase
          a = 32'($urandom_range(0, 255));
          if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_F000);
          d_access(1'($urandom_range(0, 1)), sz, a, $urandom, x_rd, x_err, x_be, x_wd, x_ad,
                   x_enl, x_vl);
        end
      end
    join

    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
